mul_job_sequencer: RTL

//  Upstream feeder and result collector for the 16x16 shift-add multiplier.
//  - Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
//  - Issues one job at a time to the multiplier and waits for its done flag.
//  - Returns products in issue order over a valid/ready result port.
//  - A watchdog flags multiplier jobs that never finish.

---
 rtl/mul_seq_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/mul_job_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg
//   Shared definitions for the multiplier job sequencer slice.
//   - seq_state_t : sequencer FSM states (IDLE, START, WAIT)
//   - MUL_W       : default operand width of the shift-add multiplier
//   - clog2_f     : constant-foldable ceil(log2) used to size pointers/counters
package mul_seq_pkg;

   localparam int MUL_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } seq_state_t;

   // Returns ceil(log2(value)); 1 and below map to 0.
   function automatic int clog2_f(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with registered occupancy and no write-to-read bypass:
//   an entry pushed in one cycle becomes visible on data_o the next cycle.
//   DEPTH must be a power of two so the pointers wrap on their own.
// Ports
//   clk_i    in   1                 clock, rising edge
//   rst_i    in   1                 asynchronous active-high reset, empties FIFO
//   push_i   in   1                 write data_i (ignored when full)
//   data_i   in   WIDTH             write data
//   pop_i    in   1                 discard head entry (ignored when empty)
//   data_o   out  WIDTH             head entry, valid while empty_o=0
//   full_o   out  1                 count == DEPTH
//   empty_o  out  1                 count == 0
//   count_o  out  log2(DEPTH)+1     number of stored entries
module sync_fifo
   import mul_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      push_i,
   input  logic [WIDTH-1:0]          data_i,
   input  logic                      pop_i,
   output logic [WIDTH-1:0]          data_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [clog2_f(DEPTH):0]   count_o
);

   localparam int AW = clog2_f(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      do_push  = push_i & ~full_o;
      do_pop   = pop_i & ~empty_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/mul_job_sequencer.sv
// mul_job_sequencer
//   Feeds operand pairs from a small FIFO to a shift-add multiplier one job at
//   a time, collects each product into a single-slot result register and
//   abandons jobs whose done flag never arrives (sticky err_o).
// Ports
//   clk_i / rst_i               clock, asynchronous active-high reset
//   in_valid_i/in_ready_o       operand stream handshake
//   in_a_i, in_b_i              operands A and B
//   mul_a_o, mul_b_o            operands held stable for the running job
//   mul_start_o                 one-cycle start pulse to the multiplier
//   mul_done_i, mul_p_i         multiplier completion and product
//   res_valid_o/res_ready_i     result handshake, res_data_o product
//   busy_o                      work queued or in flight
//   err_o, err_clr_i            sticky timeout flag and its clear
module mul_job_sequencer
   import mul_seq_pkg::*;
#(
   parameter int W       = MUL_W,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [W-1:0]     in_a_i,
   input  logic [W-1:0]     in_b_i,
   output logic [W-1:0]     mul_a_o,
   output logic [W-1:0]     mul_b_o,
   output logic             mul_start_o,
   input  logic             mul_done_i,
   input  logic [2*W-1:0]   mul_p_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [2*W-1:0]   res_data_o,
   output logic             busy_o,
   output logic             err_o,
   input  logic             err_clr_i
);

   localparam int              AW      = clog2_f(DEPTH);
   localparam int              WD_W    = clog2_f(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   seq_state_t        state_q, state_d;
   logic [W-1:0]      mul_a_q, mul_a_d;
   logic [W-1:0]      mul_b_q, mul_b_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              res_valid_q, res_valid_d;
   logic [2*W-1:0]    res_data_q, res_data_d;
   logic              err_q, err_d;
   logic              ready_en_q, ready_en_d;

   logic              fifo_push, fifo_pop;
   logic [2*W-1:0]    fifo_dout;
   logic              fifo_full, fifo_empty;
   logic [AW:0]       fifo_count;

   sync_fifo #(
      .WIDTH (2*W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  ({in_a_i, in_b_i}),
      .pop_i   (fifo_pop),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // ready_en_q keeps in_ready_o low while reset is held; afterwards the
   // ready flag follows the registered FIFO occupancy.
   assign in_ready_o  = ready_en_q & ~fifo_full;
   assign fifo_push   = in_valid_i & in_ready_o;
   assign mul_a_o     = mul_a_q;
   assign mul_b_o     = mul_b_q;
   assign mul_start_o = (state_q == START);
   assign res_valid_o = res_valid_q;
   assign res_data_o  = res_data_q;
   assign err_o       = err_q;
   assign busy_o      = (fifo_count != '0) || (state_q != IDLE);

   always_comb begin
      state_d     = state_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      wdog_d      = wdog_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      err_d       = err_q;
      ready_en_d  = 1'b1;
      fifo_pop    = 1'b0;

      if (res_valid_q && res_ready_i) begin
         res_valid_d = 1'b0;
      end
      // Clear first so a timeout in the same cycle still leaves err set.
      if (err_clr_i) begin
         err_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            // A pending result blocks issue: the result slot holds one entry.
            if (!fifo_empty && !res_valid_q) begin
               fifo_pop = 1'b1;
               mul_a_d  = fifo_dout[2*W-1:W];
               mul_b_d  = fifo_dout[W-1:0];
               state_d  = START;
            end
         end
         START: begin
            wdog_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // Done has priority over watchdog expiry in the same cycle.
            if (mul_done_i) begin
               res_data_d  = mul_p_i;
               res_valid_d = 1'b1;
               state_d     = IDLE;
            end else if (wdog_q == WD_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               wdog_d = wdog_q + WD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         wdog_q      <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         err_q       <= 1'b0;
         ready_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         wdog_q      <= wdog_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         err_q       <= err_d;
         ready_en_q  <= ready_en_d;
      end
   end

endmodule
